// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bundle of read, write, issue and hazard signals for regfile_sb.
//   Read:   a1, a2 (addr)     -> d1, d2 (data), hz1, hz2 (pending flags)
//   Write:  web, da, din
//   Issue:  bset, ba          (mark ba as awaiting a producer)
//   Status: npend             (registered count of pending registers)
// master = the pipeline driving the file, slave = regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   a1, a2;
  logic [XLEN-1:0] d1, d2;
  logic            hz1, hz2;
  logic            web;
  logic [AW-1:0]   da;
  logic [XLEN-1:0] din;
  logic            bset;
  logic [AW-1:0]   ba;
  logic [AW:0]     npend;

  modport master (
    output a1, a2, web, da, din, bset, ba,
    input  d1, d2, hz1, hz2, npend
  );

  modport slave (
    input  a1, a2, web, da, din, bset, ba,
    output d1, d2, hz1, hz2, npend
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- 2-read / 1-write register file with a per-register pending
// scoreboard. Register 0 is hard zero and never pending.
//   clk    : rising-edge clock
//   rst_n  : async active-low reset; clears storage, pending bits and count
//   bus    : regfile_sb_if.slave (read ports, write port, issue port, npend)
// With BYPASS=1 a same-cycle write is forwarded to matching read ports and
// masks their hazard flag (unless the same register is re-issued that cycle).

// One read port: data mux plus hazard flag, including forwarding.
module regfile_sb_rd #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]              a,
  input  logic                       wr_en,
  input  logic [AW-1:0]              da,
  input  logic [XLEN-1:0]            din,
  input  logic                       set_en,
  input  logic [AW-1:0]              ba,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  input  logic [NREG-1:0]            pend,
  output logic [XLEN-1:0]            d,
  output logic                       hz
);
  logic fwd;
  // wr_en already excludes da==0 and reset, so fwd never hits register 0.
  assign fwd = (BYPASS != 0) && wr_en && (da == a);

  always_comb begin
    d  = regs[a];
    hz = pend[a];
    if (a == '0) d = '0;
    if (fwd) begin
      d  = din;
      // The write retires the old producer; a same-cycle re-issue keeps it busy.
      hz = set_en && (ba == a);
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input logic        clk,
  input logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int NRD = 2;

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           pend;
  logic [AW:0]               npend;
  logic                      wr_en, set_en;
  logic                      inc, dec;

  // Qualified strobes: register 0 and the reset window are filtered here so
  // nothing downstream has to repeat those checks.
  assign wr_en  = rst_n && bus.web  && (bus.da != '0);
  assign set_en = rst_n && bus.bset && (bus.ba != '0);

  // Count deltas from the current bits: a set only counts if the bit was
  // clear; a clear only counts if the bit was set and not re-issued.
  assign inc = set_en && !pend[bus.ba];
  assign dec = wr_en && pend[bus.da] && !(set_en && (bus.ba == bus.da));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  <= '0;
      pend  <= '0;
      npend <= '0;
    end else begin
      if (wr_en) begin
        regs[bus.da] <= din_q();
        pend[bus.da] <= 1'b0;
      end
      // Issue after clear so a same-register issue wins.
      if (set_en) pend[bus.ba] <= 1'b1;
      if (inc && !dec)      npend <= npend + (AW+1)'(1);
      else if (!inc && dec) npend <= npend - (AW+1)'(1);
    end
  end

  function automatic logic [XLEN-1:0] din_q();
    return bus.din;
  endfunction

  // Read ports as an array of identical lanes.
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;
  logic [NRD-1:0]           rh;

  assign ra = {bus.a2, bus.a1};

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rd #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)
    ) u_rd (
      .a(ra[i]), .wr_en(wr_en), .da(bus.da), .din(bus.din),
      .set_en(set_en), .ba(bus.ba), .regs(regs), .pend(pend),
      .d(rd[i]), .hz(rh[i])
    );
  end

  assign bus.d1    = rd[0];
  assign bus.d2    = rd[1];
  assign bus.hz1   = rh[0];
  assign bus.hz2   = rh[1];
  assign bus.npend = npend;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_sb_if #(.XLEN(32), .NREG(32)) b1();
  regfile_sb_if #(.XLEN(32), .NREG(32)) b0();

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(b1));
  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        web;
    logic [4:0]  da;
    logic [31:0] din;
    logic        bset;
    logic [4:0]  ba;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_hz1;
    logic        e_hz2;
    logic [5:0]  e_np;   // npend after the edge
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv1(input logic web, input logic [4:0] da, input logic [31:0] din,
                      input logic bset, input logic [4:0] ba,
                      input logic [4:0] a1, input logic [4:0] a2);
    b1.web = web; b1.da = da; b1.din = din; b1.bset = bset; b1.ba = ba;
    b1.a1 = a1; b1.a2 = a2;
  endtask

  task automatic drv0(input logic web, input logic [4:0] da, input logic [31:0] din,
                      input logic bset, input logic [4:0] ba,
                      input logic [4:0] a1, input logic [4:0] a2);
    b0.web = web; b0.da = da; b0.din = din; b0.bset = bset; b0.ba = ba;
    b0.a1 = a1; b0.a2 = a2;
  endtask

  initial begin
    //        web da  din            bset ba a1 a2  e_d1           e_d2           hz1 hz2 np
    vt[0]  = '{1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd0, 32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
    vt[2]  = '{1'b1, 5'd5, 32'hAA,       1'b0, 5'd0, 5'd5, 5'd3, 32'hAA,       32'h12345678, 1'b0, 1'b0, 6'd0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hAA,       1'b0, 1'b0, 6'd1};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hAA,       1'b1, 1'b0, 6'd1};
    vt[5]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 5'd7, 32'h77,       32'h77,       1'b0, 1'b0, 6'd0};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd1};
    vt[7]  = '{1'b1, 5'd4, 32'h9,        1'b1, 5'd4, 5'd4, 5'd4, 32'h9,        32'h9,        1'b1, 1'b1, 6'd1};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd7, 32'h9,        32'h77,       1'b1, 1'b0, 6'd1};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 32'h9,        32'h0,        1'b1, 1'b0, 6'd1};
    vt[10] = '{1'b1, 5'd0, 32'hFF,       1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd1};
    vt[11] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd2, 5'd4, 5'd2, 32'h44,       32'h0,        1'b0, 1'b0, 6'd1};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd2, 32'h44,       32'h0,        1'b0, 1'b1, 6'd1};
    vt[13] = '{1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 5'd6, 5'd2, 32'h66,       32'h0,        1'b0, 1'b1, 6'd1};

    // Reset state
    rst_n = 1'b0;
    drv1(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    drv0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    #2;
    chk("rst_npend", 32'(b1.npend), 32'd0);
    chk("rst_d1", b1.d1, 32'h0);
    chk("rst_hz1", 32'(b1.hz1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: BYPASS=1 instance
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drv1(vt[i].web, vt[i].da, vt[i].din, vt[i].bset, vt[i].ba, vt[i].a1, vt[i].a2);
      #1;
      chk($sformatf("v%0d_d1", i), b1.d1, vt[i].e_d1);
      chk($sformatf("v%0d_d2", i), b1.d2, vt[i].e_d2);
      chk($sformatf("v%0d_hz1", i), 32'(b1.hz1), 32'(vt[i].e_hz1));
      chk($sformatf("v%0d_hz2", i), 32'(b1.hz2), 32'(vt[i].e_hz2));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_npend", i), 32'(b1.npend), 32'(vt[i].e_np));
    end
    @(negedge clk);
    drv1(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // BYPASS=0: write visible only after the edge, hazard not masked
    @(negedge clk);
    drv0(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    chk("nob_d1_wrcyc", b0.d1, 32'h0);
    @(posedge clk); #1;
    chk("nob_d1_next", b0.d1, 32'hAA);
    @(negedge clk);
    drv0(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5);
    #1;
    chk("nob_hz1_iss", 32'(b0.hz1), 32'd0);
    @(posedge clk); #1;
    chk("nob_hz1_pend", 32'(b0.hz1), 32'd1);
    chk("nob_npend1", 32'(b0.npend), 32'd1);
    @(negedge clk);
    drv0(1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 5'd7, 5'd5);
    #1;
    chk("nob_hz1_wrcyc", 32'(b0.hz1), 32'd1);
    chk("nob_d1_wr7", b0.d1, 32'h0);
    @(posedge clk); #1;
    chk("nob_hz1_after", 32'(b0.hz1), 32'd0);
    chk("nob_d1_after", b0.d1, 32'h70);
    chk("nob_npend0", 32'(b0.npend), 32'd0);
    @(negedge clk);
    drv0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);

    // Mid-operation reset: fill pend 1..6, REG[2]=0x55
    @(negedge clk);
    drv1(1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 5'd2, 5'd0);
    @(posedge clk);
    for (int r = 1; r <= 6; r++) begin
      @(negedge clk);
      drv1(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd2, 5'd0);
      @(posedge clk);
    end
    @(negedge clk);
    drv1(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);
    #1;
    chk("pre_rst_npend", 32'(b1.npend), 32'd6);
    chk("pre_rst_d1", b1.d1, 32'h55);
    chk("pre_rst_hz1", 32'(b1.hz1), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_npend", 32'(b1.npend), 32'd0);
    chk("async_hz1", 32'(b1.hz1), 32'd0);
    chk("async_hz2", 32'(b1.hz2), 32'd0);
    chk("async_d1", b1.d1, 32'h0);
    chk("async_nob_d1", b0.d1, 32'h0);
    // Activity during reset is ignored
    @(negedge clk);
    drv1(1'b1, 5'd2, 32'h99, 1'b1, 5'd3, 5'd2, 5'd3);
    #1;
    chk("inrst_d1", b1.d1, 32'h0);
    chk("inrst_hz2", 32'(b1.hz2), 32'd0);
    @(posedge clk); #1;
    chk("inrst_npend", 32'(b1.npend), 32'd0);
    chk("inrst_d1_post", b1.d1, 32'h0);
    // First edge after release works normally
    @(negedge clk);
    rst_n = 1'b1;
    drv1(1'b1, 5'd2, 32'h31, 1'b1, 5'd3, 5'd2, 5'd3);
    #1;
    chk("rel_d1_fwd", b1.d1, 32'h31);
    chk("rel_hz2", 32'(b1.hz2), 32'd0);
    @(posedge clk); #1;
    chk("rel_npend", 32'(b1.npend), 32'd1);
    chk("rel_hz2_set", 32'(b1.hz2), 32'd1);
    @(negedge clk);
    drv1(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd3);
    #1;
    chk("rel_d1_stored", b1.d1, 32'h31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, register count; power of two, 2..64.
REQ-003 Parameter AW, default $clog2(NREG), address width; derived, never overridden.
REQ-004 Parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = reads return stored value only.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous and active-low.
REQ-007 a1  input  AW  read port 1 address.
REQ-008 a2  input  AW  read port 2 address.
REQ-009 d1  output  XLEN  read port 1 data, combinational.
REQ-010 d2  output  XLEN  read port 2 data, combinational.
REQ-011 web  input  1  write enable, active-high.
REQ-012 da  input  AW  write address.
REQ-013 din  input  XLEN  write data.
REQ-014 bset  input  1  issue strobe; marks register ba as pending write.
REQ-015 ba  input  AW  destination register being issued.
REQ-016 hz1  output  1  register a1 has a pending write, combinational.
REQ-017 hz2  output  1  register a2 has a pending write, combinational.
REQ-018 npend  output  AW+1  count of registers currently pending, registered.

Function
REQ-019 Register 0 SHALL read as zero; writes to 0 are ignored; it is never pending.
REQ-020 On a rising edge with web=1 and da!=0, REG[da] SHALL take din.
REQ-021 d1 SHALL equal REG[a1] (d2 likewise for a2); with a1=0, d1=0.
REQ-022 With BYPASS=1, web=1, da!=0 and a1==da, d1 SHALL equal din in the same cycle; same rule for d2.
REQ-023 With BYPASS=0, reads in the write cycle SHALL return the old value; new value visible the cycle after.
REQ-024 Scoreboard: one pending bit per register; bset=1 with ba!=0 SHALL set pend[ba] at the edge.
REQ-025 web=1 with da!=0 SHALL clear pend[da] at the edge, whether or not it was set.
REQ-026 bset and web in the same cycle with ba==da SHALL leave pend[ba]=1 (new producer wins); data write still occurs.
REQ-027 bset to an already-pending register SHALL leave it pending; npend unchanged.
REQ-028 hz1 SHALL be pend[a1]; with BYPASS=1, hz1 SHALL be 0 when web=1 and da==a1, unless bset=1 and ba==a1 in the same cycle; hz2 likewise.
REQ-029 npend SHALL equal the population count of pend after each edge; it SHALL never exceed NREG-1 or underflow.
REQ-030 npend update per edge: +1 for a newly set bit, -1 for a cleared set bit, net 0 for REQ-026 or for set and clear on different registers.
REQ-031 Out-of-range addresses cannot occur (NREG is a power of two); no special handling.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, clear every REG to 0, every pend bit to 0, and npend to 0.
REQ-033 While rst_n=0, writes and bset SHALL be ignored; d1/d2 read 0, hz1/hz2 read 0.
REQ-034 First edge after rst_n rises SHALL operate normally; no extra idle cycle.
REQ-035 Reset asserted mid-operation SHALL discard all pending bits and register contents.

Verification
REQ-036 Reset, write da=3 din=0x12345678, next cycle a1=3 -> d1=0x12345678; a2=0 -> d2=0.
REQ-037 BYPASS=1: web=1 da=5 din=0xAA while a1=5 -> d1=0xAA same cycle; BYPASS=0 same stimulus -> d1=old value (0), next cycle 0xAA.
REQ-038 bset ba=7, then a1=7 -> hz1=1, npend=1; web da=7 -> hz1=0 in write cycle (BYPASS=1), npend=0 after edge.
REQ-039 Same cycle bset ba=4 and web da=4 din=9 with pend[4]=1 -> REG[4]=9, pend[4]=1, npend unchanged.
REQ-040 bset ba=0 and web da=0 din=0xFF -> d1(a1=0)=0, hz1=0, npend=0.
REQ-041 Set pend on regs 1..6 (npend=6), write REG[2]=0x55, drop rst_n between edges -> npend, hz, and d1 at a1=2 read 0 immediately.
